// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the IR command controller.
//   - byte offsets of the NEC frame fields inside the 32-bit decoder word
//   - controller FSM state encoding
//   - FIFO entry layout {addr, cmd, rpt}
//   - saturating 8-bit increment used by the event counters
package ir_pkg;

    localparam int BYTE_W       = 8;
    localparam int ADDR_LSB     = 0;
    localparam int ADDR_INV_LSB = 8;
    localparam int CMD_LSB      = 16;
    localparam int CMD_INV_LSB  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ACK   = 2'd2
    } state_t;

    // "repeat" is a reserved word, hence rpt
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] cmd;
        logic       rpt;
    } fifo_entry_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// ir_cmd_fifo: synchronous FIFO of decoded IR codes.
//   clk, rst_n : clock, async active-low clear (contents are zeroed)
//   push/wdata : write request; taken when not full, or when full and
//                a pop happens on the same edge
//   pop        : read request; ignored when empty
//   rdata      : head entry, straight from storage registers
//   full/empty : occupancy flags, decoded from the count register
module ir_cmd_fifo
    import ir_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t wdata,
    input  logic        pop,
    output fifo_entry_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fifo_entry_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // when full, the slot being written is the one leaving through the pop
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: handshakes NEC frames out of the IR decoder, validates the
// inverse bytes, buffers good codes for a consumer and flags repeats.
//   clk, rst_n          : clock, async active-low reset
//   ir_ready/ir_command : decoder frame-valid level and 32-bit frame
//   ir_ack              : frame consumed, held until ir_ready drops
//   out_valid/out_ready : FIFO head handshake
//   out_addr/out_cmd    : head code
//   out_repeat          : head equals the previous accepted code, within window
//   err_count           : saturating count of inverse-check failures
//   drop_count          : saturating count of good frames lost to a full FIFO
module ir_cmd_ctrl
    import ir_pkg::*;
#(
    parameter int          DEPTH         = 4,
    parameter bit          ADDR_CHECK    = 1'b1,
    parameter logic [15:0] REPEAT_WINDOW = 16'd4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_ready,
    input  logic [31:0] ir_command,
    output logic        ir_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_addr,
    output logic [7:0]  out_cmd,
    output logic        out_repeat,
    output logic [7:0]  err_count,
    output logic [7:0]  drop_count
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] frame;
    logic [7:0]  addr;
    logic [7:0]  addr_inv;
    logic [7:0]  cmd;
    logic [7:0]  cmd_inv;
    logic        frame_ok;
    logic        eval;
    logic        is_rpt;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        err_evt;
    logic        drop_evt;
    fifo_entry_t wdata;
    fifo_entry_t rdata;
    logic [15:0] last_pair;
    logic        last_vld;
    logic [15:0] win_cnt;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ACK only exits on ir_ready low, so IDLE always sees a fresh rise
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ir_ready) state_nxt = CHECK;
            CHECK:   state_nxt = ACK;
            ACK:     if (!ir_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        frame <= '0;
        else if (state == IDLE && ir_ready) frame <= ir_command;
    end

    assign ir_ack = (state == ACK);

    // -------------------------------------------------------------- check
    assign addr     = frame[ADDR_LSB     +: BYTE_W];
    assign addr_inv = frame[ADDR_INV_LSB +: BYTE_W];
    assign cmd      = frame[CMD_LSB      +: BYTE_W];
    assign cmd_inv  = frame[CMD_INV_LSB  +: BYTE_W];

    assign frame_ok = (cmd == ~cmd_inv) && (!ADDR_CHECK || (addr == ~addr_inv));
    assign eval     = (state == CHECK);

    assign pop      = out_valid && out_ready;
    assign push     = eval && frame_ok && (!full || pop);
    assign drop_evt = eval && frame_ok && full && !pop;
    assign err_evt  = eval && !frame_ok;

    // --------------------------------------------------------- repeat track
    assign is_rpt = last_vld && ({addr, cmd} == last_pair) && (win_cnt < REPEAT_WINDOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pair <= '0;
            last_vld  <= 1'b0;
            win_cnt   <= '0;
        end else if (push) begin
            last_pair <= {addr, cmd};
            last_vld  <= 1'b1;
            win_cnt   <= '0;
        end else if (win_cnt < REPEAT_WINDOW) begin
            win_cnt   <= win_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------ counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (err_evt)  err_count  <= sat_inc(err_count);
            if (drop_evt) drop_count <= sat_inc(drop_count);
        end
    end

    // ---------------------------------------------------------------- FIFO
    always_comb begin
        wdata      = '0;
        wdata.addr = addr;
        wdata.cmd  = cmd;
        wdata.rpt  = is_rpt;
    end

    ir_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign out_valid  = !empty;
    assign out_addr   = rdata.addr;
    assign out_cmd    = rdata.cmd;
    assign out_repeat = rdata.rpt;

endmodule

// File: doc/ir_cmd_ctrl.md
# ir_cmd_ctrl

Controller that sits between the IR frame decoder and the rest of the design. It handshakes each decoded 32-bit frame out of the decoder with `ack` and checks the NEC inverse bytes. Valid codes are buffered in a small FIFO for a downstream consumer, and repeated keys are flagged. Rejected and dropped frames are counted.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_CHECK`, 1: 1 = frame also rejected when the address inverse byte mismatches.
- `REPEAT_WINDOW`, 16'd4000: clk cycles after an accepted frame during which an identical frame is marked repeat.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ir_ready` in 1: decoder frame-valid level.
- `ir_command` in 32: decoder frame; `[7:0]` addr, `[15:8]` ~addr, `[23:16]` cmd, `[31:24]` ~cmd.
- `ir_ack` out 1: frame consumed, to decoder.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts head.
- `out_addr` out 8: head address.
- `out_cmd` out 8: head command.
- `out_repeat` out 1: head is a repeat of the previous accepted code.
- `err_count` out 8: saturating count of inverse-check failures.
- `drop_count` out 8: saturating count of valid frames lost to a full FIFO.

## Operation
- FSM states:
  - IDLE: on `ir_ready`=1, latch `ir_command` and go to CHECK.
  - CHECK: evaluate the frame, then go to ACK.
  - ACK: hold `ir_ack`=1 until `ir_ready`=0 is sampled, then go to IDLE.
- Valid frame: `cmd == ~cmd_inv`, and, when `ADDR_CHECK`=1, `addr == ~addr_inv`.
- On the CHECK→ACK transition:
  - Invalid frame: `err_count`+1.
  - Valid frame, FIFO not full or popping this cycle: push {addr, cmd, repeat}.
  - Valid frame, FIFO full and not popping: discard it and `drop_count`+1.
- Counters saturate at 255. They clear only on reset.
- Repeat: window counter (16-bit) restarts at 0 on every push and saturates at `REPEAT_WINDOW`. The pushed repeat bit is 1 when {addr, cmd} equals the last pushed pair and the counter is below `REPEAT_WINDOW`. The last-pushed register is invalid after reset, so the first push is never a repeat.
- Invalid and dropped frames do not update the last-pushed pair or the window.
- FIFO pop: `out_valid && out_ready` at a clock edge. The head changes on the next cycle.
- A simultaneous push and pop keeps the count unchanged.

## Timing
- Reset values: `ir_ack`=0, `out_valid`=0, `out_addr`=0, `out_cmd`=0, `out_repeat`=0, `err_count`=0, `drop_count`=0. The FSM resets to IDLE and the FIFO to empty.
- `ir_ready` sampled high at edge N:
  - Frame latched at N, state CHECK.
  - Push/count update and state ACK at N+1.
  - `ir_ack`=1 from N+1.
  - `out_valid`=1 from N+1 if the FIFO was empty.
- `ir_ack` falls at the edge after `ir_ready`=0 is sampled in ACK.
- A frame is never processed twice: IDLE requires a fresh `ir_ready` rise after the ACK exit.
- `ir_ready` held high indefinitely: the FSM stays in ACK with `ir_ack`=1. FIFO pops continue.
- `rst_n` low at any point, including mid-ACK: all outputs drop asynchronously to their reset values and the FIFO contents are lost.
- FIFO outputs come straight from registers (no combinational path from `out_ready` to `out_valid`).

## Structure
- Package `ir_pkg`:
  - Frame field offsets.
  - FSM state enum (IDLE, CHECK, ACK).
  - FIFO entry struct {addr[7:0], cmd[7:0], repeat}.
- Sub-module `ir_cmd_fifo`: synchronous FIFO, `DEPTH` parameter, `rst_n` async clear, push/pop/full/empty.
- The FSM, checks, repeat tracking and counters live in `ir_cmd_ctrl`.

## Test plan
- Frame 32'hBF40_FF00 (addr 00, cmd 40), `out_ready`=1:
  - `ir_ack` at N+1.
  - `out_valid` with `out_addr`=00, `out_cmd`=40, `out_repeat`=0.
  - `err_count`=0.
- Frame 32'hBF41_FF00 (bad cmd inverse): no push, `err_count`=1. With `ADDR_CHECK`=1, frame 32'hBF40_FE00 also yields `err_count`+1.
- `out_ready`=0, five valid frames with `DEPTH`=4: four entries held, `drop_count`=1. Then pop all four in original order.
- Same valid frame twice, 1000 cycles apart: second entry has `out_repeat`=1. Same frame again 5000 cycles later: `out_repeat`=0.
- `ir_ready` held high 100 cycles:
  - Exactly one push, `ir_ack` high throughout.
  - `ir_ack` falls one cycle after `ir_ready` falls.
- `rst_n` pulsed low during ACK with two FIFO entries: `ir_ack`, `out_valid` and both counters go 0 immediately. The next frame is accepted normally with `out_repeat`=0.
